// File: rtl/twiddle_cmul4_pkg.sv
// Shared widths, rounding and saturation constants for the twiddle multiplier.
// Latency: n/a (constants, types and one combinational helper).
// Backpressure: n/a.
package twiddle_cmul4_pkg;

    localparam int DATA_W  = 24;             // signed data component width
    localparam int TW_W    = 21;             // signed twiddle width, Q1.20
    localparam int TW_FRAC = 20;             // twiddle fractional bits = product shift
    localparam int TAG_W   = 8;              // sideband tag width
    localparam int LANES   = 4;

    localparam int PROD_W  = DATA_W + TW_W;  // full-precision partial product
    localparam int SUM_W   = PROD_W + 1;     // sum/difference of two products

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [TW_W-1:0]   tw_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    // Round-half-up constant: one half LSB of the shifted result.
    localparam sum_t ROUND_C = {{(SUM_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};
    // Output clamp limits, sign-extended to the sum width.
    localparam sum_t SAT_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam sum_t SAT_MIN = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Round half up, drop the twiddle fraction, clamp to the data range.
    function automatic data_t round_sat(input sum_t s);
        sum_t r;
        r = (s + ROUND_C) >>> TW_FRAC;
        if (r > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return r[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/twiddle_cmul4_cmul_lane.sv
// One lane of complex multiply y = x*w with round-half-up and saturation.
// Latency: 3 enabled cycles (operands, partial products, round/saturate).
// Backpressure: every register holds while en_i is low.
module twiddle_cmul4_cmul_lane
    import twiddle_cmul4_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     byp_i,   // bypass flag of the beat now in stage 2
    input  logic signed [DATA_W-1:0] xr_i,
    input  logic signed [DATA_W-1:0] xi_i,
    input  logic signed [TW_W-1:0]   wr_i,
    input  logic signed [TW_W-1:0]   wi_i,
    output logic signed [DATA_W-1:0] yr_o,
    output logic signed [DATA_W-1:0] yi_o
);

    data_t xr1_q, xi1_q, xr2_q, xi2_q;
    tw_t   wr1_q, wi1_q;
    prod_t p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    data_t yr_d, yi_d, yr_q, yi_q;

    // Stages 1 and 2: capture operands, then the four full-width partial
    // products; x rides alongside so bypass can return it untouched.
    always_ff @(posedge clk) begin
        if (en_i) begin
            xr1_q  <= xr_i;
            xi1_q  <= xi_i;
            wr1_q  <= wr_i;
            wi1_q  <= wi_i;
            p_rr_q <= PROD_W'(xr1_q) * PROD_W'(wr1_q);
            p_ii_q <= PROD_W'(xi1_q) * PROD_W'(wi1_q);
            p_ri_q <= PROD_W'(xr1_q) * PROD_W'(wi1_q);
            p_ir_q <= PROD_W'(xi1_q) * PROD_W'(wr1_q);
            xr2_q  <= xr1_q;
            xi2_q  <= xi1_q;
        end
    end

    // Stage 3 next value: exact passthrough on bypass, else sum then round/saturate.
    always_comb begin
        yr_d = round_sat(SUM_W'(p_rr_q) - SUM_W'(p_ii_q));
        yi_d = round_sat(SUM_W'(p_ri_q) + SUM_W'(p_ir_q));
        if (byp_i) begin
            yr_d = xr2_q;
            yi_d = xi2_q;
        end
    end

    // Stage 3 register; cleared by reset so outputs read zero after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yr_q <= '0;
            yi_q <= '0;
        end else if (en_i) begin
            yr_q <= yr_d;
            yi_q <= yi_d;
        end
    end

    assign yr_o = yr_q;
    assign yi_o = yi_q;

endmodule

// File: rtl/twiddle_cmul4.sv
// Four-lane radix-4 twiddle complex multiplier with tag and bypass pipes.
// Latency: 3 cycles from acceptance to out_valid, 1 beat/cycle throughput.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready drops.
module twiddle_cmul4
    import twiddle_cmul4_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     bypass,
    input  logic signed [DATA_W-1:0] x0_re, x1_re, x2_re, x3_re,
    input  logic signed [DATA_W-1:0] x0_im, x1_im, x2_im, x3_im,
    input  logic signed [TW_W-1:0]   w0_re, w1_re, w2_re, w3_re,
    input  logic signed [TW_W-1:0]   w0_im, w1_im, w2_im, w3_im,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y0_re, y1_re, y2_re, y3_re,
    output logic signed [DATA_W-1:0] y0_im, y1_im, y2_im, y3_im,
    output logic [TAG_W-1:0]         tag_out
);

    logic             en;
    logic             v1_q, v2_q, v3_q;
    logic             byp1_q, byp2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

    data_t x_re [LANES];
    data_t x_im [LANES];
    tw_t   w_re [LANES];
    tw_t   w_im [LANES];
    data_t y_re [LANES];
    data_t y_im [LANES];

    // One global enable: advance unless the output beat is stuck.
    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    assign x_re = '{x0_re, x1_re, x2_re, x3_re};
    assign x_im = '{x0_im, x1_im, x2_im, x3_im};
    assign w_re = '{w0_re, w1_re, w2_re, w3_re};
    assign w_im = '{w0_im, w1_im, w2_im, w3_im};

    // Valid chain and output tag; reset drops every beat in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            tag3_q <= '0;
        end else if (en) begin
            v1_q   <= in_valid;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            tag3_q <= tag2_q;
        end
    end

    // Early tag and bypass stages; contents of bubbles are don't-care.
    always_ff @(posedge clk) begin
        if (en) begin
            tag1_q <= tag_in;
            tag2_q <= tag1_q;
            byp1_q <= bypass;
            byp2_q <= byp1_q;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        twiddle_cmul4_cmul_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (en),
            .byp_i (byp2_q),
            .xr_i  (x_re[g]),
            .xi_i  (x_im[g]),
            .wr_i  (w_re[g]),
            .wi_i  (w_im[g]),
            .yr_o  (y_re[g]),
            .yi_o  (y_im[g])
        );
    end

    assign out_valid = v3_q;
    assign tag_out   = tag3_q;
    assign y0_re = y_re[0];
    assign y1_re = y_re[1];
    assign y2_re = y_re[2];
    assign y3_re = y_re[3];
    assign y0_im = y_im[0];
    assign y1_im = y_im[1];
    assign y2_im = y_im[2];
    assign y3_im = y_im[3];

endmodule

// File: tb/tb_twiddle_cmul4.sv
// Bench for twiddle_cmul4: directed vectors, backpressure, reset, random traffic.
// Reference: plain integer complex multiply, round-half-up, clamp.
// Inputs driven on the falling edge, outputs sampled just after it.
module tb_twiddle_cmul4;
    import twiddle_cmul4_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, in_ready, bypass, out_valid, out_ready;
    logic signed [DATA_W-1:0] x_re [4];
    logic signed [DATA_W-1:0] x_im [4];
    logic signed [TW_W-1:0]   w_re [4];
    logic signed [TW_W-1:0]   w_im [4];
    logic signed [DATA_W-1:0] y_re [4];
    logic signed [DATA_W-1:0] y_im [4];
    logic [TAG_W-1:0] tag_in, tag_out;

    twiddle_cmul4 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bypass(bypass),
        .x0_re(x_re[0]), .x1_re(x_re[1]), .x2_re(x_re[2]), .x3_re(x_re[3]),
        .x0_im(x_im[0]), .x1_im(x_im[1]), .x2_im(x_im[2]), .x3_im(x_im[3]),
        .w0_re(w_re[0]), .w1_re(w_re[1]), .w2_re(w_re[2]), .w3_re(w_re[3]),
        .w0_im(w_im[0]), .w1_im(w_im[1]), .w2_im(w_im[2]), .w3_im(w_im[3]),
        .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
        .y0_re(y_re[0]), .y1_re(y_re[1]), .y2_re(y_re[2]), .y3_re(y_re[3]),
        .y0_im(y_im[0]), .y1_im(y_im[1]), .y2_im(y_im[2]), .y3_im(y_im[3]),
        .tag_out(tag_out)
    );

    typedef struct packed {
        logic [3:0][DATA_W-1:0] yr;
        logic [3:0][DATA_W-1:0] yi;
        logic [TAG_W-1:0]       tag;
    } beat_t;

    typedef struct {
        int lane;
        int xr, xi, wr, wi;
        bit byp;
        int er, ei;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    beat_t q[$];
    bit    acc_f, xfer_f;
    int    xfer_tag;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer product, add half LSB, floor-shift, clamp.
    function automatic longint rnd_sat(input longint s);
        longint r;
        r = (s + (longint'(1) <<< (TW_FRAC - 1))) >>> TW_FRAC;
        if (r > (longint'(1) <<< (DATA_W - 1)) - 1) r = (longint'(1) <<< (DATA_W - 1)) - 1;
        if (r < -(longint'(1) <<< (DATA_W - 1)))    r = -(longint'(1) <<< (DATA_W - 1));
        return r;
    endfunction

    function automatic beat_t model();
        beat_t  b;
        longint xr, xi, wr, wi, pr, pi;
        for (int i = 0; i < 4; i++) begin
            xr = longint'(x_re[i]);
            xi = longint'(x_im[i]);
            wr = longint'(w_re[i]);
            wi = longint'(w_im[i]);
            pr = bypass ? xr : rnd_sat(xr * wr - xi * wi);
            pi = bypass ? xi : rnd_sat(xr * wi + xi * wr);
            b.yr[i] = DATA_W'(pr);
            b.yi[i] = DATA_W'(pi);
        end
        b.tag = tag_in;
        return b;
    endfunction

    function automatic beat_t cur_out();
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.yr[i] = y_re[i];
            b.yi[i] = y_im[i];
        end
        b.tag = tag_out;
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_d();
        case ($urandom_range(0, 3))
            0:       return {1'b0, {(DATA_W-1){1'b1}}};
            1:       return {1'b1, {(DATA_W-1){1'b0}}};
            default: return DATA_W'($urandom);
        endcase
    endfunction

    function automatic logic [TW_W-1:0] rnd_w();
        case ($urandom_range(0, 3))
            0:       return {1'b0, {(TW_W-1){1'b1}}};
            1:       return {1'b1, {(TW_W-1){1'b0}}};
            default: return TW_W'($urandom);
        endcase
    endfunction

    task automatic rand_data();
        for (int i = 0; i < 4; i++) begin
            x_re[i] = rnd_d();
            x_im[i] = rnd_d();
            w_re[i] = rnd_w();
            w_im[i] = rnd_w();
        end
    endtask

    // One clock: account for the handshakes the coming edge will perform,
    // then move on to the next falling edge.
    task automatic tick();
        beat_t e, g;
        #1;
        acc_f  = 1'b0;
        xfer_f = 1'b0;
        if (out_valid === 1'b1 && out_ready) begin
            xfer_f   = 1'b1;
            xfer_tag = int'(tag_out);
            g        = cur_out();
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL stale_beat: out_valid with tag %0d, nothing pending", tag_out);
            end else begin
                e = q.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL beat_data: got %h expected %h", g, e);
                end
            end
        end
        if (!rst_n) q.delete();
        else if (in_valid && in_ready) begin
            acc_f = 1'b1;
            q.push_back(model());
        end
        @(negedge clk);
    endtask

    task automatic send_vec(input vec_t v, input int idx);
        int lat;
        rand_data();
        x_re[v.lane] = DATA_W'(v.xr);
        x_im[v.lane] = DATA_W'(v.xi);
        w_re[v.lane] = TW_W'(v.wr);
        w_im[v.lane] = TW_W'(v.wi);
        bypass    = v.byp;
        tag_in    = TAG_W'(idx + 16);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("vec_accept", acc_f, 1);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check("vec_latency", lat, 3);
        check("vec_y_re", int'(y_re[v.lane]), v.er);
        check("vec_y_im", int'(y_im[v.lane]), v.ei);
        check("vec_tag", int'(tag_out), idx + 16);
        tick();
    endtask

    vec_t vt[6];

    initial begin
        int    next_tag, outs, stall_left;
        bit    need_new;
        int    got_tags[$];
        beat_t snap;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bypass = 1'b0; tag_in = '0;
        for (int i = 0; i < 4; i++) begin
            x_re[i] = '0; x_im[i] = '0; w_re[i] = '0; w_im[i] = '0;
        end

        vt[0] = '{lane:0, xr:1000,     xi:-7,       wr:12345,   wi:-54321,   byp:1, er:1000,     ei:-7};
        vt[1] = '{lane:1, xr:1000,     xi:0,        wr:0,       wi:-1048575, byp:0, er:0,        ei:-1000};
        vt[2] = '{lane:2, xr:1,        xi:0,        wr:524288,  wi:0,        byp:0, er:1,        ei:0};
        vt[3] = '{lane:2, xr:-1,       xi:0,        wr:524288,  wi:0,        byp:0, er:0,        ei:0};
        vt[4] = '{lane:3, xr:8388607,  xi:8388607,  wr:1048575, wi:-1048575, byp:0, er:8388607,  ei:0};
        vt[5] = '{lane:3, xr:-8388608, xi:-8388608, wr:1048575, wi:-1048575, byp:0, er:-8388608, ei:0};

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_tag_out", tag_out, 0);
        for (int i = 0; i < 4; i++) begin
            check("rst_y_re", y_re[i], 0);
            check("rst_y_im", y_im[i], 0);
        end
        rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int v = 0; v < 6; v++) send_vec(vt[v], v);

        // Backpressure: 6 tagged beats, 4-cycle stall after the second output
        next_tag = 1; outs = 0; stall_left = 0; need_new = 1'b1; bypass = 1'b0;
        for (int c = 0; c < 60 && outs < 6; c++) begin
            if (need_new) begin
                rand_data();
                need_new = 1'b0;
            end
            in_valid = (next_tag <= 6);
            tag_in   = TAG_W'(next_tag);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                #1;
                check("bp_in_ready", in_ready, 0);
            end else begin
                out_ready = 1'b1;
            end
            tick();
            if (acc_f) begin
                next_tag++;
                need_new = 1'b1;
            end
            if (xfer_f) begin
                got_tags.push_back(xfer_tag);
                outs++;
                if (outs == 2) begin
                    stall_left = 4;
                    snap = cur_out();
                end
            end else if (stall_left > 0) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_data", (cur_out() === snap) ? 1 : 0, 1);
                stall_left--;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got_tags.size(), 6);
        for (int k = 0; k < got_tags.size(); k++) check("bp_tag_order", got_tags[k], k + 1);

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            rand_data();
            tag_in   = TAG_W'(64 + k);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_tag", tag_out, 0);
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_y_re", y_re[i], 0);
            check("mid_rst_y_im", y_im[i], 0);
        end
        rst_n = 1'b1;
        repeat (6) tick();
        send_vec(vt[1], 7);

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rand_data();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            bypass    = ($urandom_range(0, 4) == 0);
            tag_in    = TAG_W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) tick();
        check("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/twiddle_cmul4.md
Name: twiddle_cmul4

Overview:
- Four-lane pipelined complex multiplier that applies radix-4 DIF twiddle factors to the four butterfly outputs of each radix-4 group.
- Sits directly downstream of the twiddle-factor generator, which is combinational from stage/sub_stage, and upstream of the cache write-back.
- Twiddles and butterfly data are sampled together on each accepted beat.
- Rounds and saturates each result back to the data width.

Parameters:
- DATA_W, 24: signed width of each real/imag data component.
- TW_W, 21: signed twiddle width, Q1.20; +1.0 is represented as 2^20-1 = 1048575.
- TW_FRAC, 20: twiddle fractional bits, equal to the product right-shift.
- TAG_W, 8: width of the sideband tag (cache address/stage info) carried with the data.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- bypass  in  1  pass data unmultiplied (final stage / bit-reverse phase)
- x0_re..x3_re, x0_im..x3_im  in  DATA_W each  signed butterfly outputs, lanes 0-3
- w0_re..w3_re, w0_im..w3_im  in  TW_W each  signed twiddles, lanes 0-3
- tag_in  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- y0_re..y3_re, y0_im..y3_im  out  DATA_W each  signed products
- tag_out  out  TAG_W  tag aligned with y*

Behaviour:
- Pipeline and stall:
  - 3-stage pipeline: S1 registers operands; S2 registers the 4 partial products per lane; S3 registers sum, round and saturate.
  - Latency is exactly 3 cycles from acceptance to out_valid when out_ready stays high.
  - Global enable en = !out_valid || out_ready. All stages, including valid bits, advance only when en=1.
  - in_ready = en, combinational. A beat is accepted when in_valid && in_ready.
  - Bubbles propagate as valid=0. Data registers of invalid stages may hold don't-care values.
  - Under backpressure (out_valid=1, out_ready=0) every stage holds. y*, tag_out and out_valid stay stable, and no beat is dropped or duplicated.
  - Full throughput is 1 beat per cycle with continuous out_ready.
- Reset:
  - Synchronous when rst_n=0 at a clk edge: all valid bits clear, so out_valid=0.
  - All y* and tag_out are 0.
  - A reset mid-stream discards in-flight beats.
  - During reset in_ready reflects en, i.e. 1 once out_valid is cleared.
- Arithmetic, per lane:
  - pr = xr*wr - xi*wi; pi = xr*wi + xi*wr.
  - Products are DATA_W+TW_W bits; the sum is DATA_W+TW_W+1 bits, no intermediate truncation.
  - Rounding is round-half-up: add 2^(TW_FRAC-1), then arithmetic shift right by TW_FRAC.
  - Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Bypass:
  - bypass is sampled with the beat and travels down the pipeline.
  - When set, y = x exactly for all lanes; twiddles are ignored and latency is still 3.
  - This avoids the (1-2^-20) gain error of the W^0 encoding.
- Lane independence: each lane has its own twiddle. Lane 0 normally receives W^0 but is not special-cased in hardware.

Decomposition:
- Shared package/define file holds:
  - DATA_W, TW_W and TW_FRAC defaults (consistent with the existing rotation-factor width define).
  - The round constant.
  - The saturation min/max constants.
- One natural sub-module: cmul_lane, a single-lane 3-stage complex multiply with round/saturate and an enable input. It is instantiated 4x.
- The top level owns the valid chain, the enable/handshake logic, the bypass flag and the tag pipe.

Test Plan:
- Identity bypass: x0=(1000,-7), bypass=1, any twiddle -> y0=(1000,-7) 3 cycles later, tag_out equals tag_in.
- -j rotation: x1=(1000,0), w1=(0,-1048575), bypass=0 -> y1=(0,-1000).
- Rounding: x2=(1,0), w2=(524288,0) -> y2=(1,0); and x2=(-1,0), same w2 -> y2=(0,0).
- Saturation: x3=(8388607,8388607), w3=(1048575,-1048575) -> y3=(8388607,0). Also x3=(-8388608,-8388608), w3=(1048575,-1048575) -> y3=(-8388608,0).
- Backpressure: stream 6 beats with tags 1..6, drop out_ready for 4 cycles after the second output -> outputs stay stable while stalled, in_ready=0 while stalled, all 6 tags emerge in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 beats in flight -> out_valid=0 and y*=0 next cycle; no stale beat ever emerges; the next accepted beat appears 3 cycles after acceptance.
